// File: rtl/pipe_alu_if.sv
// Handshake bundle for pipe_alu: operation request channel and result channel.
interface pipe_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             ovfl;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, ovfl
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, ovfl
    );
endinterface

// File: rtl/pipe_alu.sv
// pipe_alu: registered ALU with valid/ready handshakes and a {Z,V,N} flag register.
// Define PIPE_ALU_MUL_EN to build the iterative signed shift-add multiplier (opcode 8).
module pipe_alu #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    pipe_alu_if.slave  bus,
    output logic [2:0] flags,
    output logic       busy
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_XOR    = 4'd2;
    localparam logic [3:0] OP_RED    = 4'd3;
    localparam logic [3:0] OP_SLL    = 4'd4;
    localparam logic [3:0] OP_SRA    = 4'd5;
    localparam logic [3:0] OP_ROR    = 4'd6;
    localparam logic [3:0] OP_PADDSB = 4'd7;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, MUL} state_t;
    state_t state, next_state;

    logic [WIDTH-1:0] result_q;
    logic             ovfl_q;
    logic             out_valid_q;

    logic             accept;
    logic             start_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;
    logic             mul_ovf;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_legal;
    logic             alu_arith;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [4:0]       nib;
    logic [SHW-1:0]   sh;

    assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.ovfl      = ovfl_q;

    // Single-cycle datapath; illegal opcodes fall through to a zero result.
    always_comb begin
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_legal = 1'b1;
        alu_arith = 1'b0;
        nib       = '0;
        sh        = bus.b[SHW-1:0];
        sum       = {bus.a[WIDTH-1], bus.a} + {bus.b[WIDTH-1], bus.b};
        diff      = {bus.a[WIDTH-1], bus.a} - {bus.b[WIDTH-1], bus.b};
        case (bus.op)
            OP_ADD: begin
                alu_arith = 1'b1;
                alu_ovf   = sum[WIDTH] ^ sum[WIDTH-1];
                alu_res   = alu_ovf ? (bus.a[WIDTH-1] ? MIN_NEG : MAX_POS) : sum[WIDTH-1:0];
            end
            OP_SUB: begin
                alu_arith = 1'b1;
                alu_ovf   = diff[WIDTH] ^ diff[WIDTH-1];
                alu_res   = alu_ovf ? (bus.a[WIDTH-1] ? MIN_NEG : MAX_POS) : diff[WIDTH-1:0];
            end
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_RED: begin
                for (int i = 0; i < WIDTH/8; i++) begin
                    alu_res = alu_res + WIDTH'($signed(bus.a[8*i +: 8]))
                                      + WIDTH'($signed(bus.b[8*i +: 8]));
                end
            end
            OP_SLL: alu_res = bus.a << sh;
            OP_SRA: alu_res = $unsigned($signed(bus.a) >>> sh);
            OP_ROR: alu_res = WIDTH'({bus.a, bus.a} >> sh);
            OP_PADDSB: begin
                for (int i = 0; i < WIDTH/4; i++) begin
                    nib = {bus.a[4*i+3], bus.a[4*i +: 4]} + {bus.b[4*i+3], bus.b[4*i +: 4]};
                    if (nib[4] != nib[3]) begin
                        alu_res[4*i +: 4] = nib[4] ? 4'h8 : 4'h7;
                        alu_ovf           = 1'b1;
                    end else begin
                        alu_res[4*i +: 4] = nib[3:0];
                    end
                end
            end
            default: alu_legal = 1'b0;
        endcase
    end

`ifdef PIPE_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd8;

    logic [SHW-1:0]     count;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               neg;

    assign abs_a     = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign abs_b     = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign start_mul = accept && (bus.op == OP_MUL);
    assign mul_done  = (state == MUL) && (count == SHW'(WIDTH - 1));
    assign busy      = (state == MUL);

    // The final step's partial sum feeds the result directly, so no extra cycle is spent.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
        prod     = neg ? -acc_next : acc_next;
        mul_res  = prod[WIDTH-1:0];
        mul_ovf  = (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}});
    end

    // Magnitude shift-add: multiplicand walks left, multiplier walks right.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
        end else if (start_mul) begin
            count  <= '0;
            mcand  <= {{WIDTH{1'b0}}, abs_a};
            mplier <= abs_b;
            acc    <= '0;
            neg    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end else if (state == MUL) begin
            count  <= mul_done ? '0 : count + SHW'(1);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_next;
        end
    end
`else
    assign start_mul = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_res   = '0;
    assign mul_ovf   = 1'b0;
    assign busy      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_mul) next_state = MUL;
            MUL:     if (mul_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A drain and a new load on the same edge leave out_valid set.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovfl_q      <= 1'b0;
            flags       <= 3'b000;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept && !start_mul) begin
                out_valid_q <= 1'b1;
                result_q    <= alu_res;
                ovfl_q      <= alu_ovf;
                if (alu_legal) begin
                    flags[2] <= (alu_res == '0);
                end
                if (alu_arith) begin
                    flags[1:0] <= {alu_ovf, alu_res[WIDTH-1]};
                end
            end else if (mul_done) begin
                out_valid_q <= 1'b1;
                result_q    <= mul_res;
                ovfl_q      <= mul_ovf;
                flags[2]    <= (mul_res == '0);
            end
        end
    end
endmodule

// File: tb/tb_pipe_alu.sv
// Scoreboard bench for pipe_alu (WIDTH=16): directed vectors in, queued expectations out.
module tb_pipe_alu;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] flags;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic [2:0]  flg;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    pipe_alu_if #(.WIDTH(16)) bus ();

    pipe_alu #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .flags (flags),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_output: got result %0h, expected no output", bus.result);
        end else begin
            e = exp_q.pop_front();
            checkVal({e.name, " result"}, 32'(bus.result), 32'(e.res));
            checkVal({e.name, " ovfl"},   32'(bus.ovfl),   32'(e.ovf));
            checkVal({e.name, " flags"},  32'(flags),      32'(e.flg));
        end
    endtask

    // Presents one operation, waits (bounded) for acceptance, queues the expectation.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] res, input logic ovf, input logic [2:0] flg,
                                 input string name);
        int n = 0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s accept_timeout: got in_ready 0, expected 1", name);
            bus.in_valid = 1'b0;
        end else begin
            e.res  = res;
            e.ovf  = ovf;
            e.flg  = flg;
            e.name = name;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checkOutput();
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 4'd0;
        bus.a         = 16'h0;
        bus.b         = 16'h0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkVal("reset result",    32'(bus.result),    32'd0);
        checkVal("reset ovfl",      32'(bus.ovfl),      32'd0);
        checkVal("reset flags",     32'(flags),         32'd0);
        checkVal("reset busy",      32'(busy),          32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkVal("in_ready after reset", 32'(bus.in_ready), 32'd1);

        applyStimulus(4'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 3'b010, "add_sat_pos");
        checkVal("add latency out_valid", 32'(bus.out_valid), 32'd1);
        applyStimulus(4'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 3'b100, "sub_zero");
        applyStimulus(4'd2, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 3'b000, "xor_a");
        applyStimulus(4'd0, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 3'b011, "add_sat_neg");
        applyStimulus(4'd2, 16'h00FF, 16'h00FF, 16'h0000, 1'b0, 3'b111, "xor_zero_hold");
        applyStimulus(4'd7, 16'h7654, 16'h1111, 16'h7765, 1'b1, 3'b011, "paddsb_pos");
        applyStimulus(4'd6, 16'h0001, 16'h0004, 16'h1000, 1'b0, 3'b011, "ror_4");
        applyStimulus(4'd6, 16'h1234, 16'h0000, 16'h1234, 1'b0, 3'b011, "ror_0");
        applyStimulus(4'd3, 16'h80FF, 16'h0102, 16'hFF82, 1'b0, 3'b011, "red");
        applyStimulus(4'd4, 16'h0003, 16'h0004, 16'h0030, 1'b0, 3'b011, "sll_4");
        applyStimulus(4'd5, 16'h8000, 16'h00FF, 16'hFFFF, 1'b0, 3'b011, "sra_15");
        applyStimulus(4'd15, 16'h1234, 16'h0001, 16'h0000, 1'b0, 3'b011, "illegal_15");
        applyStimulus(4'd0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 3'b001, "add_neg");
        applyStimulus(4'd1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 3'b011, "sub_sat_neg");
        applyStimulus(4'd7, 16'h8888, 16'h8888, 16'h8888, 1'b1, 3'b011, "paddsb_neg");
        applyStimulus(4'd4, 16'h0001, 16'h000F, 16'h8000, 1'b0, 3'b011, "sll_15");

`ifdef PIPE_ALU_MUL_EN
        applyStimulus(4'd8, 16'h0100, 16'h0100, 16'h0000, 1'b1, 3'b111, "mul_ovf");
        for (int i = 0; i < 16; i++) begin
            checkVal("mul busy/in_ready/out_valid", 32'({busy, bus.in_ready, bus.out_valid}), 32'b100);
            @(posedge clk);
            #1;
        end
        checkVal("mul done out_valid/busy", 32'({bus.out_valid, busy}), 32'b10);
        applyStimulus(4'd8, 16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, 3'b011, "mul_neg");
        applyStimulus(4'd8, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 3'b011, "mul_negneg");
        applyStimulus(4'd8, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 3'b011, "mul_min");
`else
        applyStimulus(4'd8, 16'h0100, 16'h0100, 16'h0000, 1'b0, 3'b011, "op8_illegal");
        checkVal("op8 single cycle out_valid/busy", 32'({bus.out_valid, busy}), 32'b10);
`endif

        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        applyStimulus(4'd0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 3'b000, "bp_first");
        fork
            applyStimulus(4'd0, 16'h0010, 16'h0020, 16'h0030, 1'b0, 3'b000, "bp_second");
            begin
                for (int i = 0; i < 3; i++) begin
                    checkVal("bp held valid/ready/result",
                             32'({bus.out_valid, bus.in_ready, bus.result}), {15'd0, 1'b1, 1'b0, 16'h0003});
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
                @(posedge clk);
                #1;
                checkVal("bp drain-cycle accept", 32'({bus.out_valid, bus.result}), {15'd0, 1'b1, 16'h0030});
            end
        join

        repeat (2) @(posedge clk);
        #1;
`ifdef PIPE_ALU_MUL_EN
        applyStimulus(4'd8, 16'h0100, 16'h0003, 16'h0300, 1'b0, 3'b011, "mul_reset");
        repeat (4) @(posedge clk);
        #1;
`else
        bus.out_ready = 1'b0;
        applyStimulus(4'd0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 3'b010, "held_reset");
`endif
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        checkVal("mid reset out_valid/busy/flags", 32'({bus.out_valid, busy, flags}), 32'd0);
        checkVal("mid reset result", 32'(bus.result), 32'd0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            if (bus.out_valid) seen = 1;
            @(posedge clk);
            #1;
        end
        checkVal("no output after reset", 32'(seen), 32'd0);

        applyStimulus(4'd0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 3'b000, "add_after_reset");

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkVal("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_alu.md
# pipe_alu

Parametrised, registered ALU with valid/ready handshakes on its input and output. It computes saturating add/sub, XOR, byte reduction, shifts/rotate, nibble-parallel saturating add, and an optional iterative signed multiply. It keeps a Z/V/N flag register. It sits between decode and writeback and replaces the fixed 16-bit combinational ALU in pipelined cores.

## Interface
- WIDTH, 16, datapath width; must be a multiple of 8 and at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an operation is presented.
- in_ready  output  1  the block accepts the operation this cycle.
- op  input  4  opcode; see Operation.
- a, b  input  WIDTH  operands, two's complement.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.
- ovfl  output  1  registered overflow or saturation flag for this result.
- flags  output  3  {Z,V,N} flag register.
- busy  output  1  a multiply is in progress.

## Operation
- Accept: an operation is accepted when in_valid && in_ready is high at a rising edge.
- in_ready is (state==IDLE) && (!out_valid || out_ready).
- Opcodes:
  - 0 ADD: a+b. Signed overflow saturates to 0x7F..F or 0x80..0 and sets ovfl=1.
  - 1 SUB: a-b, saturating as for ADD.
  - 2 XOR: a^b.
  - 3 RED: sign-extended sum of all WIDTH/8 signed bytes of a and of b.
  - 4 SLL: a << b[SHW-1:0].
  - 5 SRA: arithmetic a >> b[SHW-1:0].
  - 6 ROR: rotate a right by b[SHW-1:0].
  - 7 PADDSB: independent signed 4-bit lanes, each saturating. ovfl is the OR of lane saturations.
  - 8 MUL: low WIDTH bits of the signed product a*b. ovfl=1 if the full product is not representable in WIDTH signed bits.
  - 9–15 illegal: result=0, ovfl=0, flags unchanged.
- ovfl is 0 for every opcode not listed with an ovfl rule.
- Flags update on the edge that loads the result register:
  - Z = (result==0) for all legal opcodes.
  - V = ovfl and N = result[WIDTH-1], for ADD and SUB only.
  - All other flag bits hold their value.
- FSM states:
  - IDLE: single-cycle ops load the output register directly. Accepting MUL goes to MUL.
  - MUL: radix-2 shift-add on operand magnitudes with sign correction. A counter runs 0..WIDTH-1. When it reaches WIDTH-1, the result is loaded and the FSM returns to IDLE.
- Output register: holds result, ovfl and out_valid unchanged while out_valid && !out_ready.
- Simultaneous drain and accept is allowed: out_ready and a new single-cycle accept in the same cycle loads the new result. out_valid stays 1.
- Multiply result with a stalled output: cannot occur, because MUL is accepted only when the output will be free.

## Timing
- Reset values: out_valid=0, result=0, ovfl=0, flags=3'b000, busy=0, state=IDLE, counter=0. in_ready is 1 the cycle after reset.
- Single-cycle ops: accepted at edge k, so out_valid=1 after edge k. Throughput is one op per cycle with out_ready held high.
- MUL: accepted at edge k.
  - busy=1 and in_ready=0 after edges k..k+WIDTH-1.
  - result loads and out_valid=1 after edge k+WIDTH.
  - busy=0 after edge k+WIDTH.
- Reset mid-MUL or while a result is held: everything returns to reset values at that edge. The partial product is discarded and no result is produced.
- in_valid while in_ready=0: ignored. The source must hold its operation.

## Configuration
- PIPE_ALU_MUL_EN defined: MUL opcode implemented as above, including the MUL state, the counter and busy.
- Not defined: opcode 8 is treated as illegal, completing in a single cycle with result=0 and ovfl=0. busy is tied to 0, and no multiplier logic is present.

## Test plan
All scenarios use WIDTH=16.
- Saturating add: ADD a=0x7FFF, b=0x0001 -> result 0x7FFF, ovfl=1, flags {Z,V,N}=3'b010, out_valid one edge after accept.
- Zero and flag retention: SUB 0x0005-0x0005 -> 0x0000, flags=3'b100. Then XOR 0x00FF^0x0F0F -> 0x0FF0, flags=3'b000 (V and N held from the SUB).
- Nibble saturation and rotate: PADDSB 0x7654+0x1111 -> 0x7765, ovfl=1. ROR a=0x0001, b=0x0004 -> 0x1000.
- Multiply (PIPE_ALU_MUL_EN defined):
  - 0x0100*0x0100 -> 0x0000, ovfl=1, out_valid exactly 16 edges after accept, in_ready=0 and busy=1 throughout.
  - 0xFFFD*0x0007 -> 0xFFEB, ovfl=0.
- Backpressure: two back-to-back ADDs with out_ready=0 for 3 cycles -> first result held stable, in_ready=0, second accepted on the drain cycle, both results delivered in order.
- Reset mid-multiply: rst asserted 5 cycles into a MUL -> out_valid=0, flags=0, busy=0 after that edge, and no result emitted.
